// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions used by the fetch-side redirect logic.
//   OPCODE_*          : control-transfer opcodes decoded upstream of EX
//   PC_STEP           : sequential fetch increment
//   redirect_state_t  : fetch redirect FSM states
package rv32i_pkg;

  localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } redirect_state_t;

endpackage

// File: rtl/branch_perf_cnt.sv
// Branch statistics counters.
//   clk, rst_n      : clock, asynchronous active-low reset
//   br_inc          : a conditional branch retired from EX this cycle
//   taken_inc       : that branch was also taken (redirected)
//   br_count        : conditional branches counted (wraps at 2^32)
//   br_taken_count  : taken conditional branches counted (wraps at 2^32)
module branch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_inc,
  input  logic        taken_inc,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else begin
      if (br_inc)    br_count       <= br_count + 32'd1;
      if (taken_inc) br_taken_count <= br_taken_count + 32'd1;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner and EX-stage branch/jump redirect controller.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ex_valid            : EX holds a valid instruction
//   ex_is_branch        : EX instruction is a conditional branch
//   ex_is_jump          : EX instruction is JAL/JALR
//   ExeBranch           : branch comparator condition result
//   ex_target           : branch/jump target from EX
//   stall               : hazard stall, hold the PC
//   imem_ready          : instruction memory accepts the current request
//   pc, pc_valid        : fetch request (valid/ready handshake)
//   redirect            : taken branch/jump accepted this cycle
//   flush_ifid/idex     : squash IF/ID and ID/EX at the next edge
//   misalign_err        : sticky, a taken target was not word aligned
//   br_count            : conditional branches retired
//   br_taken_count      : conditional branches taken
module pc_redirect_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ExeBranch,
  input  logic [XLEN-1:0] ex_target,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            redirect,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misalign_err,
  output logic [31:0]     br_count,
  output logic [31:0]     br_taken_count
);

  redirect_state_t state_q, state_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic            take, bad, go;
  logic            br_inc, taken_inc;

  always_comb begin
    take = (state_q == RUN) && ex_valid && (ex_is_jump || (ex_is_branch && ExeBranch));
    bad  = take && (ex_target[1:0] != 2'b00);
    go   = take && !bad;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    pending_d  = pending_q;
    redirect   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state_q)
      RUN: begin
        if (go) begin
          redirect   = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          // No request is outstanding before pc_valid rises, so the PC may
          // be replaced freely; otherwise it must wait for the handshake.
          if (imem_ready || !pc_valid) begin
            pc_d = ex_target;
          end else begin
            pending_d = ex_target;
            state_d   = HOLD;
          end
        end else if (pc_valid && imem_ready && !stall) begin
          pc_d = pc + PC_STEP;
        end
      end
      HOLD: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        if (imem_ready) begin
          pc_d    = pending_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc           <= RESET_PC;
      pending_q    <= '0;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      pending_q <= pending_d;
      pc_valid  <= 1'b1;
      if (bad) misalign_err <= 1'b1;
    end
  end

  always_comb begin
    br_inc    = (state_q == RUN) && ex_valid && ex_is_branch && !stall;
    taken_inc = br_inc && go;
  end

  branch_perf_cnt u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_inc         (br_inc),
    .taken_inc      (taken_inc),
    .br_count       (br_count),
    .br_taken_count (br_taken_count)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_branch, ex_is_jump, ExeBranch;
  logic [31:0] ex_target;
  logic        stall, imem_ready;
  logic [31:0] pc;
  logic        pc_valid, redirect, flush_ifid, flush_idex, misalign_err;
  logic [31:0] br_count, br_taken_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ExeBranch      (ExeBranch),
    .ex_target      (ex_target),
    .stall          (stall),
    .imem_ready     (imem_ready),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .redirect       (redirect),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .misalign_err   (misalign_err),
    .br_count       (br_count),
    .br_taken_count (br_taken_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ExeBranch = 0; ex_target = '0;
  endtask

  task automatic ex_br(input logic cond, input logic [31:0] tgt);
    ex_valid = 1; ex_is_branch = 1; ex_is_jump = 0; ExeBranch = cond; ex_target = tgt;
  endtask

  task automatic ex_jmp(input logic [31:0] tgt);
    ex_valid = 1; ex_is_branch = 0; ex_is_jump = 1; ExeBranch = 0; ex_target = tgt;
  endtask

  initial begin
    rst_n = 0; stall = 0; imem_ready = 1;
    ex_idle();
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_valid", {31'b0, pc_valid}, 32'd0);
    chk("rst_flush", {29'b0, redirect, flush_ifid, flush_idex}, 32'd0);
    chk("rst_cnt", br_count | br_taken_count, 32'd0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
    tick(); tick();
    rst_n = 1;
    #1 chk("pre_valid", {31'b0, pc_valid}, 32'd0);

    // Free run: first fetch at RESET_PC, then sequential.
    tick();
    chk("run_pc0", pc, 32'h0);
    chk("run_valid", {31'b0, pc_valid}, 32'd1);
    tick(); chk("run_pc4", pc, 32'h4);
    tick(); chk("run_pc8", pc, 32'h8);

    // BEQ taken, memory ready.
    ex_br(1, 32'h100);
    #1 chk("beq_flags", {29'b0, redirect, flush_ifid, flush_idex}, 32'd7);
    tick(); ex_idle();
    chk("beq_pc", pc, 32'h100);
    chk("beq_taken_cnt", br_taken_count, 32'd1);
    chk("beq_br_cnt", br_count, 32'd1);

    // BNE not taken.
    ex_br(0, 32'h300);
    #1 chk("bne_flags", {29'b0, redirect, flush_ifid, flush_idex}, 32'd0);
    tick(); ex_idle();
    chk("bne_pc", pc, 32'h104);
    chk("bne_br_cnt", br_count, 32'd2);
    chk("bne_taken_cnt", br_taken_count, 32'd1);

    // JAL with memory not ready: take cycle + 2 HOLD cycles low, then release.
    imem_ready = 0;
    ex_jmp(32'h200);
    #1 chk("jal_flags", {29'b0, redirect, flush_ifid, flush_idex}, 32'd7);
    tick();
    ex_br(1, 32'h700);  // ignored while in HOLD
    #1 chk("hold1_flags", {29'b0, redirect, flush_ifid, flush_idex}, 32'd3);
    chk("hold1_pc", pc, 32'h104);
    tick();
    #1 chk("hold2_flags", {29'b0, redirect, flush_ifid, flush_idex}, 32'd3);
    chk("hold2_pc", pc, 32'h104);
    imem_ready = 1;
    #1 chk("hold_rel_flags", {29'b0, redirect, flush_ifid, flush_idex}, 32'd3);
    tick(); ex_idle();
    chk("jal_pc", pc, 32'h200);
    chk("hold_br_cnt", br_count, 32'd2);
    #1 chk("post_hold_flags", {29'b0, redirect, flush_ifid, flush_idex}, 32'd0);

    // Misaligned taken target.
    ex_br(1, 32'h102);
    #1 chk("mis_flags", {29'b0, redirect, flush_ifid, flush_idex}, 32'd0);
    tick(); ex_idle();
    chk("mis_pc", pc, 32'h204);
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_cnts", {br_count[15:0], br_taken_count[15:0]}, {16'd3, 16'd1});
    tick();
    chk("mis_sticky", {31'b0, misalign_err}, 32'd1);
    chk("mis_pc2", pc, 32'h208);

    // Taken branch under stall: redirect wins, counters not advanced.
    stall = 1;
    ex_br(1, 32'h400);
    #1 chk("stall_flags", {29'b0, redirect, flush_ifid, flush_idex}, 32'd7);
    tick(); ex_idle();
    chk("stall_pc", pc, 32'h400);
    tick();
    chk("stall_hold_pc", pc, 32'h400);
    chk("stall_cnts", {br_count[15:0], br_taken_count[15:0]}, {16'd3, 16'd1});
    stall = 0;

    // Wrap modulo 2^32.
    ex_jmp(32'hFFFF_FFFC);
    tick(); ex_idle();
    chk("wrap_tgt", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc, 32'h0);

    // Reset asserted mid-HOLD discards the pending target.
    imem_ready = 0;
    ex_jmp(32'h500);
    tick(); ex_idle();
    #1 chk("hold_enter", {31'b0, flush_ifid}, 32'd1);
    rst_n = 0;
    #1;
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_valid", {31'b0, pc_valid}, 32'd0);
    chk("mrst_cnt", br_count | br_taken_count, 32'd0);
    chk("mrst_flush", {29'b0, redirect, flush_ifid, flush_idex}, 32'd0);
    chk("mrst_misalign", {31'b0, misalign_err}, 32'd0);
    imem_ready = 1;
    tick();
    rst_n = 1;
    tick();
    chk("mrst_run_pc0", pc, 32'h0);
    tick();
    chk("mrst_run_pc4", pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
